// File: rtl/irq_stim_gen.sv
// rtl/irq_stim_gen.sv - address-triggered multi-channel interrupt stimulus generator
// Each channel arms on a CTRL write, waits DELAY after a PC match, then pulses irq for WIDTH or until ack.
module irq_stim_gen #(
  parameter int NCH    = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_valid,
  input  logic [NCH-1:0]    ack,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  output logic [NCH-1:0]    irq,
  output logic              irq_any,
  output logic [NCH-1:0]    fired
);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_ACTIVE, S_CLEAR, S_DONE} state_t;

  logic [ADDR_W-1:0] trig    [NCH];
  logic [CNT_W-1:0]  dly     [NCH];
  logic [CNT_W-1:0]  wid     [NCH];
  logic [2:0]        ctrl    [NCH];  // {hold, rearm, arm}
  state_t            state   [NCH];
  state_t            state_n [NCH];
  logic [CNT_W-1:0]  cnt     [NCH];
  logic [CNT_W-1:0]  cnt_n   [NCH];
  logic [CNT_W-1:0]  wid_eff [NCH];
  logic [NCH-1:0]    match;
  logic [NCH-1:0]    cfg_hit;
  logic [NCH-1:0]    ctrl_wr;
  logic [NCH-1:0]    irq_n;

  // A CTRL write overrides whatever the channel would otherwise do on this edge.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      cfg_hit[ch] = cfg_we && (int'(cfg_ch) == ch);
      ctrl_wr[ch] = cfg_hit[ch] && (cfg_sel == 2'd3);
      match[ch]   = addr_valid && (addr == trig[ch]);
      wid_eff[ch] = (wid[ch] == '0) ? CNT_W'(1) : wid[ch];
      state_n[ch] = state[ch];
      cnt_n[ch]   = cnt[ch];
      if (ctrl_wr[ch]) begin
        state_n[ch] = cfg_wdata[0] ? S_ARMED : S_IDLE;
      end else begin
        case (state[ch])
          S_ARMED: begin
            if (match[ch]) begin
              if (dly[ch] == '0) begin
                state_n[ch] = S_ACTIVE;
                cnt_n[ch]   = wid_eff[ch];
              end else begin
                state_n[ch] = S_DELAY;
                cnt_n[ch]   = dly[ch];
              end
            end
          end
          S_DELAY: begin
            if (cnt[ch] == CNT_W'(1)) begin
              state_n[ch] = S_ACTIVE;
              cnt_n[ch]   = wid_eff[ch];
            end else begin
              cnt_n[ch] = cnt[ch] - CNT_W'(1);
            end
          end
          S_ACTIVE: begin
            if (ctrl[ch][2] ? ack[ch] : (cnt[ch] == CNT_W'(1))) begin
              state_n[ch] = ctrl[ch][1] ? S_CLEAR : S_DONE;
            end else if (!ctrl[ch][2]) begin
              cnt_n[ch] = cnt[ch] - CNT_W'(1);
            end
          end
          S_CLEAR: begin
            // hold off until the PC has left TRIG so a parked PC does not retrigger
            if (!match[ch]) state_n[ch] = S_ARMED;
          end
          default: ;
        endcase
      end
      irq_n[ch] = (state_n[ch] == S_ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        trig[ch]  <= '0;
        dly[ch]   <= '0;
        wid[ch]   <= CNT_W'(1);
        ctrl[ch]  <= '0;
        state[ch] <= S_IDLE;
        cnt[ch]   <= '0;
      end
      irq     <= '0;
      fired   <= '0;
      irq_any <= 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state[ch] <= state_n[ch];
        cnt[ch]   <= cnt_n[ch];
        if (cfg_hit[ch]) begin
          case (cfg_sel)
            2'd0: trig[ch] <= cfg_wdata;
            2'd1: dly[ch]  <= cfg_wdata[CNT_W-1:0];
            2'd2: wid[ch]  <= cfg_wdata[CNT_W-1:0];
            2'd3: ctrl[ch] <= cfg_wdata[2:0];
          endcase
        end
      end
      irq     <= irq_n;
      fired   <= irq_n & ~irq;
      irq_any <= |irq_n;
    end
  end
endmodule

// File: tb/tb_irq_stim_gen.sv
// tb/tb_irq_stim_gen.sv - bench for irq_stim_gen: directed scenarios plus randomized traffic
// Expected outputs come from a timestamp-based reference model of each channel.
module tb_irq_stim_gen;
  localparam int NCH    = 6;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [NCH-1:0]    ack;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_sel;
  logic [ADDR_W-1:0] cfg_wdata;
  logic [NCH-1:0]    irq;
  logic              irq_any;
  logic [NCH-1:0]    fired;

  irq_stim_gen #(.NCH(NCH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .addr_valid(addr_valid), .ack(ack),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .irq(irq), .irq_any(irq_any), .fired(fired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t;
  int fcnt [NCH];
  int hcnt [NCH];
  logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h108, 32'h10c};

  // Reference model: a trigger becomes a rise time and a last-high time; hold pulses end on ack.
  logic [31:0] m_trig  [NCH];
  int          m_dly   [NCH];
  int          m_wid   [NCH];
  logic [2:0]  m_ctrl  [NCH];
  bit          m_listen[NCH];
  bit          m_block [NCH];
  int          rise_at [NCH];
  int          last_hi [NCH];
  logic [NCH-1:0] exp_irq   = '0;
  logic [NCH-1:0] exp_fired = '0;

  task automatic model_edge();
    logic [NCH-1:0] nirq;
    bit mt;
    bit stop;
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_trig[ch] = '0; m_dly[ch] = 0; m_wid[ch] = 1; m_ctrl[ch] = '0;
        m_listen[ch] = 0; m_block[ch] = 0; rise_at[ch] = -1; last_hi[ch] = -1;
      end
      exp_irq = '0;
      exp_fired = '0;
      return;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      mt = addr_valid && (addr == m_trig[ch]);
      if (cfg_we && int'(cfg_ch) == ch && cfg_sel == 2'd3) begin
        m_listen[ch] = cfg_wdata[0];
        m_block[ch]  = 0;
        rise_at[ch]  = -1;
      end else if (exp_irq[ch]) begin
        stop = m_ctrl[ch][2] ? ack[ch] : (cyc == last_hi[ch]);
        if (stop) begin
          rise_at[ch] = -1;
          m_block[ch] = m_ctrl[ch][1];
        end
      end else if (rise_at[ch] > cyc) begin
      end else if (m_block[ch]) begin
        if (!mt) begin
          m_block[ch]  = 0;
          m_listen[ch] = 1;
        end
      end else if (m_listen[ch] && mt) begin
        rise_at[ch]  = cyc + 1 + m_dly[ch];
        m_listen[ch] = 0;
      end
      if (rise_at[ch] == cyc + 1) last_hi[ch] = cyc + ((m_wid[ch] == 0) ? 1 : m_wid[ch]);
      nirq[ch] = (rise_at[ch] >= 0) && (cyc + 1 >= rise_at[ch]) &&
                 (m_ctrl[ch][2] || (cyc + 1 <= last_hi[ch]));
    end
    exp_fired = nirq & ~exp_irq;
    exp_irq   = nirq;
    if (cfg_we && int'(cfg_ch) < NCH) begin
      case (cfg_sel)
        2'd0: m_trig[cfg_ch] = cfg_wdata;
        2'd1: m_dly[cfg_ch]  = int'(cfg_wdata[7:0]);
        2'd2: m_wid[cfg_ch]  = int'(cfg_wdata[7:0]);
        2'd3: m_ctrl[cfg_ch] = cfg_wdata[2:0];
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("fired", 32'(fired), 32'(exp_fired));
    chk("irq_any", 32'(irq_any), 32'(|exp_irq));
    for (int ch = 0; ch < NCH; ch++) begin
      if (fired[ch]) fcnt[ch]++;
      if (irq[ch]) hcnt[ch]++;
    end
  endtask

  task automatic clr();
    for (int ch = 0; ch < NCH; ch++) begin
      fcnt[ch] = 0;
      hcnt[ch] = 0;
    end
  endtask

  task automatic wr(input int ch, input int sel, input logic [31:0] d);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 2'(sel); cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pc(input logic [31:0] a, input int n);
    addr = a; addr_valid = 1'b1;
    repeat (n) step();
    addr = '0; addr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; addr = '0; addr_valid = 1'b0; ack = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
    clr();
    idle(2);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_fired", 32'(fired), 32'h0);
    reset = 1'b0;
    idle(2);

    // ch0 one-shot, delay 5, width 6
    wr(0, 0, 32'h301c); wr(0, 1, 5); wr(0, 2, 6); wr(0, 3, 1);
    clr();
    t = cyc;
    pc(32'h301c, 1);
    repeat (14) begin
      chk("t1_irq0", 32'(irq[0]), 32'((cyc >= t + 6) && (cyc <= t + 11)));
      step();
    end
    chk("t1_fired_cnt", fcnt[0], 1);
    clr();
    pc(32'h301c, 1);
    idle(12);
    chk("t1_revisit", fcnt[0], 0);

    // ch1 rearm, zero delay/width, PC parked then revisits
    wr(1, 0, 32'h4198); wr(1, 1, 0); wr(1, 2, 0); wr(1, 3, 3);
    clr();
    pc(32'h4198, 4); idle(3); pc(32'h4198, 2); idle(3);
    chk("t2_pulses", fcnt[1], 2);
    chk("t2_high_cycles", hcnt[1], 2);

    // ch2 hold mode, acked at t+10
    wr(2, 0, 32'h5000); wr(2, 1, 2); wr(2, 3, 5);
    clr();
    t = cyc;
    pc(32'h5000, 1);
    repeat (9) step();
    chk("t3_high_before_ack", 32'(irq[2]), 32'h1);
    chk("t3_high_cycles", hcnt[2], 8);
    ack = 6'b000100;
    step();
    ack = '0;
    chk("t3_low_after_ack", 32'(irq[2]), 32'h0);
    clr();
    pc(32'h5000, 1); idle(8);
    chk("t3_done", fcnt[2], 0);

    // ch3 and ch5 share a trigger with different delays
    wr(3, 0, 32'h3000); wr(3, 1, 1); wr(3, 2, 4); wr(3, 3, 1);
    wr(5, 0, 32'h3000); wr(5, 1, 3); wr(5, 2, 4); wr(5, 3, 1);
    pc(32'h3000, 1);
    step();
    chk("t4_irq_t2", 32'(irq), 32'h08);
    chk("t4_any_t2", 32'(irq_any), 32'h1);
    idle(2);
    chk("t4_irq_t4", 32'(irq), 32'h28);
    idle(6);

    // ch0 disarmed mid-delay, then re-armed
    wr(0, 1, 5); wr(0, 3, 1);
    clr();
    pc(32'h301c, 1); idle(2);
    wr(0, 3, 0);
    idle(10);
    chk("t5_no_fire", fcnt[0], 0);
    chk("t5_no_high", hcnt[0], 0);
    wr(0, 1, 0); wr(0, 3, 1);
    pc(32'h301c, 1); idle(8);
    chk("t5_rearmed", fcnt[0], 1);

    // reset during ch4 ACTIVE
    wr(4, 0, 32'h6000); wr(4, 2, 10); wr(4, 3, 1);
    pc(32'h6000, 1); idle(2);
    chk("t6_active", 32'(irq[4]), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_irq_cleared", 32'(irq), 32'h0);
    chk("t6_any_cleared", 32'(irq_any), 32'h0);
    clr();
    pc(32'h6000, 3); idle(5);
    chk("t6_no_fire", fcnt[4], 0);
    wr(4, 0, 32'h6000); wr(4, 3, 1);
    pc(32'h6000, 1); idle(3);
    chk("t6_reconfigured", fcnt[4], 1);

    // out-of-range channel writes
    wr(6, 3, 1); wr(7, 0, 32'h100); idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      addr_valid = ($urandom_range(0, 99) < 70);
      addr       = pool[$urandom_range(0, 3)];
      ack        = NCH'($urandom & $urandom);
      reset      = ($urandom_range(0, 999) < 3);
      cfg_we     = ($urandom_range(0, 99) < 12);
      cfg_ch     = CH_W'($urandom_range(0, 7));
      cfg_sel    = 2'($urandom_range(0, 3));
      case (cfg_sel)
        2'd0:    cfg_wdata = pool[$urandom_range(0, 3)];
        2'd1,
        2'd2:    cfg_wdata = 32'($urandom_range(0, 4));
        default: cfg_wdata = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0);
      endcase
      step();
    end
    reset = 1'b0; cfg_we = 1'b0; ack = '0; addr_valid = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
